as_pipe_acc: RTL and testbench

Parametrised, pipelined signed adder/subtractor with a running accumulator, saturation mode and valid/ready flow control. It is the next generation of the team's 30-bit combinational add/sub unit: the width is generic, a registered 2-stage datapath is added, and an accumulator lets successive results chain. It sits between an operand producer and a result consumer, and both sides use valid/ready handshakes.

---
 rtl/as_pkg.sv | 21 ++
 rtl/as_core.sv | 36 +++
 rtl/as_pipe_acc.sv | 128 ++++++++++++
 tb/tb_as_pipe_acc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/as_pkg.sv
// Shared definitions for the pipelined add/sub accumulator: op encoding and default width.
package as_pkg;

  localparam int AS_WIDTH = 30;

  typedef enum logic [1:0] {
    OP_ADD     = 2'd0,
    OP_SUB     = 2'd1,
    OP_ACC_ADD = 2'd2,
    OP_ACC_SUB = 2'd3
  } as_op_e;

  function automatic logic op_is_acc(input logic [1:0] op);
    return (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
  endfunction

  function automatic logic op_is_sub(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_ACC_SUB);
  endfunction

endpackage

// File: rtl/as_core.sv
// Combinational signed add/sub on WIDTH+1-bit operands with overflow detection
// and optional clamp to the WIDTH+1-bit signed range.
module as_core
  import as_pkg::*;
#(
  parameter int WIDTH = AS_WIDTH
) (
  input  logic signed [WIDTH:0] operand_a,
  input  logic signed [WIDTH:0] operand_b,
  input  logic                  sub,
  input  logic                  sat,
  output logic signed [WIDTH:0] result,
  output logic                  ovf
);

  logic signed [WIDTH+1:0] sum_wide;
  logic signed [WIDTH:0]   max_val;
  logic signed [WIDTH:0]   min_val;

  always_comb begin
    max_val = {1'b0, {WIDTH{1'b1}}};
    min_val = {1'b1, {WIDTH{1'b0}}};
    if (sub) begin
      sum_wide = {operand_a[WIDTH], operand_a} - {operand_b[WIDTH], operand_b};
    end else begin
      sum_wide = {operand_a[WIDTH], operand_a} + {operand_b[WIDTH], operand_b};
    end
    // The two top bits disagree exactly when the sum leaves the WIDTH+1 range.
    ovf    = sum_wide[WIDTH+1] ^ sum_wide[WIDTH];
    result = sum_wide[WIDTH:0];
    if (ovf && sat) begin
      result = sum_wide[WIDTH+1] ? min_val : max_val;
    end
  end

endmodule

// File: rtl/as_pipe_acc.sv
// Two-stage valid/ready add/sub pipeline with a running accumulator that always
// holds the most recent result; stage B and Acc are written on the same edge.
module as_pipe_acc
  import as_pkg::*;
#(
  parameter int WIDTH = AS_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    In_valid,
  output logic                    In_ready,
  input  logic signed [WIDTH-1:0] In_1,
  input  logic signed [WIDTH-1:0] In_2,
  input  logic [1:0]              Op,
  input  logic                    Sat,
  output logic                    Out_valid,
  input  logic                    Out_ready,
  output logic signed [WIDTH:0]   Out,
  output logic                    Ovf
);

  logic                    a_valid_q, a_valid_d;
  logic signed [WIDTH-1:0] a_in1_q, a_in1_d;
  logic signed [WIDTH-1:0] a_in2_q, a_in2_d;
  logic [1:0]              a_op_q, a_op_d;
  logic                    a_sat_q, a_sat_d;

  logic                    b_valid_q, b_valid_d;
  logic signed [WIDTH:0]   out_q, out_d;
  logic                    ovf_q, ovf_d;
  logic signed [WIDTH:0]   acc_q, acc_d;

  logic                    b_advance;
  logic                    in_accept;
  logic                    is_acc;
  logic signed [WIDTH:0]   core_a, core_b, core_result;
  logic                    core_sub, core_sat, core_ovf;

  assign b_advance = !b_valid_q || Out_ready;
  assign In_ready  = !rst && (!a_valid_q || b_advance);
  assign in_accept = In_valid && In_ready;

  // Accumulate ops pair Acc with In_1; exact ops pair the two inputs.
  always_comb begin
    is_acc   = op_is_acc(a_op_q);
    core_sub = op_is_sub(a_op_q);
    core_sat = is_acc && a_sat_q;
    if (is_acc) begin
      core_a = acc_q;
      core_b = {a_in1_q[WIDTH-1], a_in1_q};
    end else begin
      core_a = {a_in1_q[WIDTH-1], a_in1_q};
      core_b = {a_in2_q[WIDTH-1], a_in2_q};
    end
  end

  as_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .operand_a(core_a),
    .operand_b(core_b),
    .sub      (core_sub),
    .sat      (core_sat),
    .result   (core_result),
    .ovf      (core_ovf)
  );

  always_comb begin
    a_valid_d = a_valid_q;
    a_in1_d   = a_in1_q;
    a_in2_d   = a_in2_q;
    a_op_d    = a_op_q;
    a_sat_d   = a_sat_q;
    if (in_accept) begin
      a_valid_d = 1'b1;
      a_in1_d   = In_1;
      a_in2_d   = In_2;
      a_op_d    = Op;
      a_sat_d   = Sat;
    end else if (b_advance) begin
      a_valid_d = 1'b0;
    end
  end

  always_comb begin
    b_valid_d = b_valid_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    if (b_advance) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        out_d = core_result;
        ovf_d = core_ovf;
        acc_d = core_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
    end
  end

  // Stage A payload is only meaningful alongside a_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    a_in1_q <= a_in1_d;
    a_in2_q <= a_in2_d;
    a_op_q  <= a_op_d;
    a_sat_q <= a_sat_d;
  end

  assign Out_valid = b_valid_q;
  assign Out       = out_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_as_pipe_acc.sv
// Directed checks of as_pipe_acc (WIDTH=30) plus a randomized stream against a reference model.
module tb_as_pipe_acc;
  import as_pkg::*;

  localparam int W = 30;
  localparam longint MAXV = (longint'(1) << W) - 1;
  localparam longint MINV = -(longint'(1) << W);
  localparam longint MODV = longint'(1) << (W + 1);
  localparam longint M29  = 536870911;   // 2^29-1
  localparam longint N29  = -536870912;  // -2^29

  logic                clk = 1'b0;
  logic                rst;
  logic                In_valid;
  logic                In_ready;
  logic signed [W-1:0] In_1;
  logic signed [W-1:0] In_2;
  logic [1:0]          Op;
  logic                Sat;
  logic                Out_valid;
  logic                Out_ready;
  logic signed [W:0]   Out;
  logic                Ovf;

  typedef struct {
    longint out;
    bit     ovf;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     rand_en = 1'b0;
  longint acc_m = 0;

  always #5 clk = ~clk;

  as_pipe_acc #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .In_1     (In_1),
    .In_2     (In_2),
    .Op       (Op),
    .Sat      (Sat),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .Out      (Out),
    .Ovf      (Ovf)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference model: wide arithmetic, then explicit range test and clamp/wrap.
  function automatic void model(input int op, input longint a, input longint b, input bit sat,
                                output longint r, output bit o);
    longint s;
    o = 1'b0;
    if (op == 0)      r = a + b;
    else if (op == 1) r = a - b;
    else begin
      s = (op == 2) ? acc_m + a : acc_m - a;
      r = s;
      if (s > MAXV) begin
        o = 1'b1;
        r = sat ? MAXV : s - MODV;
      end else if (s < MINV) begin
        o = 1'b1;
        r = sat ? MINV : s + MODV;
      end
    end
    acc_m = r;
  endfunction

  function automatic longint rnd_operand();
    logic [31:0] u;
    u = $urandom();
    case ($urandom_range(5))
      0:       return M29;
      1:       return N29;
      2:       return longint'($urandom_range(3));
      default: return u[W-1] ? longint'(u[W-1:0]) - (longint'(1) << W) : longint'(u[W-1:0]);
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the item was accepted.
  task automatic issue(input int op, input longint a, input longint b, input bit sat,
                       input longint e, input bit eo);
    int   guard;
    exp_t x;
    logic [1:0] opv;
    guard    = 0;
    opv      = op[1:0];
    In_valid = 1'b1;
    In_1     = a[W-1:0];
    In_2     = b[W-1:0];
    Op       = opv;
    Sat      = sat;
    #1;
    while (In_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("in_ready_wait", In_ready, 1);
    x.out = e;
    x.ovf = eo;
    exp_q.push_back(x);
    @(negedge clk);
    In_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    exp_t   e;
    int     op;
    bit     sat;
    longint a, b, r;
    bit     o;

    rst       = 1'b1;
    In_valid  = 1'b0;
    In_1      = '0;
    In_2      = '0;
    Op        = 2'd0;
    Sat       = 1'b0;
    Out_ready = 1'b1;

    // Output monitor and random backpressure, sampled mid-low-phase.
    fork
      forever begin
        @(negedge clk);
        if (rand_en) Out_ready = ($urandom_range(3) != 0);
        #3;
        if (rst === 1'b0 && Out_valid === 1'b1 && Out_ready === 1'b1) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL spurious_out: got Out=%0d with nothing pending, expected no result", Out);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out", Out, e.out);
            chk("ovf", Ovf, e.ovf);
          end
        end
      end
    join_none

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", In_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", Out_valid, 0);
    chk("rst_out", Out, 0);
    chk("rst_ovf", Ovf, 0);
    chk("rst_in_ready_after", In_ready, 1);
    @(negedge clk);

    // Exact ops streamed, with first-result latency
    issue(OP_ADD, 3, 4, 1'b0, 7, 1'b0);
    #1;
    chk("lat_not_yet", Out_valid, 0);
    issue(OP_SUB, 7, -6, 1'b0, 13, 1'b0);
    #1;
    chk("lat_valid", Out_valid, 1);
    chk("lat_out", Out, 7);
    issue(OP_ADD, -1, -2, 1'b0, -3, 1'b0);
    issue(OP_SUB, -9, 8, 1'b0, -17, 1'b0);
    issue(OP_ADD, M29, M29, 1'b0, 1073741822, 1'b0);
    issue(OP_SUB, N29, M29, 1'b0, -1073741823, 1'b0);
    drain();

    // Accumulate overflow: saturate then wrap, then underflow mirror
    issue(OP_ADD, M29, M29, 1'b0, 1073741822, 1'b0);
    issue(OP_ACC_ADD, 1, 12345, 1'b0, 1073741823, 1'b0);
    issue(OP_ACC_ADD, 1, 0, 1'b1, 1073741823, 1'b1);
    issue(OP_ADD, M29, M29, 1'b0, 1073741822, 1'b0);
    issue(OP_ACC_ADD, 1, -7, 1'b0, 1073741823, 1'b0);
    issue(OP_ACC_ADD, 1, 0, 1'b0, -1073741824, 1'b1);
    issue(OP_ADD, N29, N29, 1'b0, -1073741824, 1'b0);
    issue(OP_ACC_SUB, 1, 99, 1'b1, -1073741824, 1'b1);
    issue(OP_ADD, N29, N29, 1'b0, -1073741824, 1'b0);
    issue(OP_ACC_SUB, 1, 0, 1'b0, 1073741823, 1'b1);
    drain();

    // Backpressure: two accepts fill the pipe, third waits
    Out_ready = 1'b0;
    issue(OP_ADD, 100, 1, 1'b0, 101, 1'b0);
    issue(OP_SUB, 50, 20, 1'b0, 30, 1'b0);
    In_valid = 1'b1;
    In_1     = 30'sd5;
    In_2     = 30'sd5;
    Op       = OP_ADD;
    Sat      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", In_ready, 0);
      chk("stall_out_valid", Out_valid, 1);
      chk("stall_out", Out, 101);
      @(negedge clk);
    end
    Out_ready = 1'b1;
    #1;
    chk("release_in_ready", In_ready, 1);
    e.out = 10;
    e.ovf = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    In_valid = 1'b0;
    issue(OP_ACC_ADD, 1, 0, 1'b0, 11, 1'b0);
    drain();

    // Reset with both stages full, B holding an overflowed result
    issue(OP_ADD, M29, M29, 1'b0, 1073741822, 1'b0);
    issue(OP_ACC_ADD, 1, 0, 1'b0, 1073741823, 1'b0);
    drain();
    Out_ready = 1'b0;
    issue(OP_ACC_ADD, 1, 0, 1'b1, 1073741823, 1'b1);
    issue(OP_ACC_ADD, 3, 0, 1'b0, -1073741822, 1'b1);
    #1;
    chk("pre_rst_out", Out, 1073741823);
    chk("pre_rst_ovf", Ovf, 1);
    @(negedge clk);
    rst      = 1'b1;
    In_valid = 1'b1;
    In_1     = 30'sd77;
    Op       = OP_ACC_ADD;
    #1;
    chk("mid_rst_in_ready", In_ready, 0);
    @(negedge clk);
    rst      = 1'b0;
    In_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("post_rst_out_valid", Out_valid, 0);
    chk("post_rst_out", Out, 0);
    chk("post_rst_ovf", Ovf, 0);
    @(negedge clk);
    Out_ready = 1'b1;
    issue(OP_ACC_ADD, 5, 0, 1'b0, 5, 1'b0);
    drain();
    repeat (4) @(negedge clk);

    // Randomized ops and stalls against the model
    acc_m = 0;
    issue(OP_ADD, 0, 0, 1'b0, 0, 1'b0);
    rand_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      op  = int'($urandom_range(3));
      sat = 1'(($urandom_range(1)));
      a   = rnd_operand();
      b   = rnd_operand();
      model(op, a, b, sat, r, o);
      issue(op, a, b, sat, r, o);
      if ($urandom_range(7) == 0) @(negedge clk);
    end
    rand_en   = 1'b0;
    Out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
